// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 receive sequencer with mid-bit sampling and a one-entry valid/ready output register.
module uart_rx_ctrl #(
    parameter int DIV         = 434,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       enable_i,
    input  logic       ready_i,
    input  logic       clr_err_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int CW = $clog2(DIV);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0] arm;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic rs, rs_prev, fall, tick, in_frame, free, load, drop, bad_stop;

    assign rs = sync[SYNC_STAGES-1];
    // edges are ignored until the synchroniser holds real line samples, so a line held low through reset never starts a frame
    assign fall = arm[SYNC_STAGES] & rs_prev & ~rs;
    assign tick = cnt == '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync    <= '1;
            arm     <= '0;
            rs_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx_i};
            arm     <= {arm[SYNC_STAGES-1:0], 1'b1};
            rs_prev <= rs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (fall && enable_i) state_nx = START;
            START:     if (tick) state_nx = rs ? IDLE : DATA;
            DATA:      if (tick && idx == 3'd7) state_nx = STOP;
            STOP:      if (tick) state_nx = rs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_frame = state == START || state == DATA || state == STOP;
        free     = ~valid_o | ready_i;
        load     = state == STOP && tick && rs && free;
        drop     = state == STOP && tick && rs && !free;
        bad_stop = state == STOP && tick && !rs;
        busy_o   = state != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            cnt         <= (state == IDLE && fall && enable_i) ? CW'(DIV / 2 - 1) :
                           in_frame ? (tick ? CW'(DIV - 1) : cnt - 1'b1) : '0;
            idx         <= state == START ? 3'd0 : (state == DATA && tick) ? idx + 3'd1 : idx;
            shift       <= (state == DATA && tick) ? {rs, shift[7:1]} : shift;
            data_o      <= load ? shift : data_o;
            valid_o     <= load | (valid_o & ~ready_i);
            frame_err_o <= bad_stop | (frame_err_o & ~clr_err_i);
            overrun_o   <= drop | (overrun_o & ~clr_err_i);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random 8N1 frames checked against a byte-level model of expected deliveries and flags.
module tb_uart_rx_ctrl;
    localparam int DIV = 8;
    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b0, en = 1'b1, rdy = 1'b1, clr = 1'b0;
    logic [7:0] data;
    logic valid, busy, ferr, ovr;
    logic [7:0] gotq[$], expq[$];
    int checks = 0, errors = 0, vcyc = 0, bcyc = 0;

    uart_rx_ctrl #(.DIV(DIV), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx), .enable_i(en), .ready_i(rdy),
        .clr_err_i(clr), .data_o(data), .valid_o(valid), .busy_o(busy),
        .frame_err_o(ferr), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && rdy) gotq.push_back(data);
            if (valid) vcyc++;
            if (busy) bcyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int drop_at);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_at) en = 1'b0;
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) chk({tag, "_byte"}, gotq[i], expq[i]);
    endtask

    initial begin
        int v0, b0;
        logic err_exp;
        logic [7:0] b;
        logic stop;
        int gap;
        tick(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", ferr, 1'b0);
        chk("rst_ovr", ovr, 1'b0);
        rst_n = 1'b1;
        tick(10);
        rx = 1'b1;
        tick(5);
        chk("no_false_start", bcyc, 0);

        v0 = vcyc;
        send(8'hA5, 1'b1, -1);
        tick(3);
        expq.push_back(8'hA5);
        check_rx("a5");
        chk("a5_valid_cycles", vcyc - v0, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_flags", {ferr, ovr}, 2'b00);

        b0 = bcyc;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3 * DIV);
        chk("glitch_busy_pulse", (bcyc - b0) > 0, 1'b1);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_flags", {ferr, ovr, valid}, 3'b000);
        check_rx("glitch");

        send(8'h3C, 1'b0, -1);
        tick(30);
        rx = 1'b1;
        tick(DIV);
        chk("ferr_set", ferr, 1'b1);
        send(8'h81, 1'b1, -1);
        tick(3);
        expq.push_back(8'h81);
        check_rx("after_ferr");
        tick(10);
        chk("ferr_sticky", ferr, 1'b1);
        chk("ferr_no_ovr", ovr, 1'b0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ferr_cleared", ferr, 1'b0);

        rdy = 1'b0;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        tick(2);
        chk("ovr_data", data, 8'h11);
        chk("ovr_valid", valid, 1'b1);
        chk("ovr_flag", ovr, 1'b1);
        chk("ovr_no_ferr", ferr, 1'b0);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        tick(1);
        chk("ovr_drained", valid, 1'b0);
        expq.push_back(8'h11);
        check_rx("ovr");
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovr_cleared", ovr, 1'b0);

        rdy = 1'b1;
        send(8'h55, 1'b1, -1);
        send(8'hAA, 1'b1, -1);
        tick(3);
        expq.push_back(8'h55);
        expq.push_back(8'hAA);
        check_rx("b2b");

        en = 1'b0;
        b0 = bcyc;
        send(8'h42, 1'b1, -1);
        tick(3);
        chk("en_off_busy", bcyc - b0, 0);
        check_rx("en_off");
        en = 1'b1;
        tick(DIV);

        send(8'hC3, 1'b1, 2);
        en = 1'b1;
        tick(3);
        expq.push_back(8'hC3);
        check_rx("en_drop");
        chk("en_drop_data", data, 8'hC3);

        b = 8'h99;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        chk("midrst_outs", {data, valid, busy, ferr, ovr}, 12'h000);
        rst_n = 1'b1;
        tick(2 * DIV);
        send(8'h7E, 1'b1, -1);
        tick(3);
        expq.push_back(8'h7E);
        check_rx("midrst");
        chk("midrst_data", data, 8'h7E);

        err_exp = 1'b0;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            gap = $urandom_range(0, 2) + (stop ? 0 : 1);
            send(b, stop, -1);
            rx = 1'b1;
            tick(gap * DIV);
            if (stop) expq.push_back(b);
            else err_exp = 1'b1;
        end
        tick(3);
        check_rx("rand");
        chk("rand_ferr", ferr, err_exp);
        chk("rand_ovr", ovr, 1'b0);
        chk("rand_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receive path. It synchronises the serial line, detects the start bit, generates mid-bit sample strobes from a clock divider, and assembles 8N1 frames LSB-first. It validates start and stop bits, then hands each byte to the system side through a one-entry valid/ready output register with sticky framing and overrun flags. It sits between the rx pin and the UART register/FIFO layer.

Parameters:
DIV, 434, clk_i cycles per bit (50 MHz / 115200); legal range 4..65535; counter width $clog2(DIV)
SYNC_STAGES, 2, flops in the rx_i synchroniser; minimum 2

Ports:
clk_i  in  1  system clock, only clock
rst_i  in  1  asynchronous active-low reset
rx_i  in  1  serial line, idle high, asynchronous to clk_i
enable_i  in  1  1 = new frames may start; a frame already in progress always completes
ready_i  in  1  consumer accepts data_o this cycle
clr_err_i  in  1  clears frame_err_o and overrun_o
data_o  out  8  received byte, stable while valid_o=1
valid_o  out  1  data_o holds an unconsumed byte
busy_o  out  1  1 whenever FSM is not IDLE
frame_err_o  out  1  sticky: stop bit sampled as 0
overrun_o  out  1  sticky: good byte dropped because output register full

Behaviour:
- Reset (async, rst_i=0): FSM=IDLE, synchroniser flops and previous-sample flop =1, counters 0, shift reg 0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0. No false start on reset release with rx_i low.
- rs = synchronised rx_i, SYNC_STAGES cycles of latency. Falling edge = rs_prev=1 and rs=0.
- Edge detection cycle = T. Sample points are at T + DIV/2 + k*DIV, where DIV/2 uses integer division. k=0 is the start bit, k=1..8 are data bits d0..d7, and k=9 is the stop bit.
- IDLE: on a falling edge with enable_i=1, go to START and load the bit counter. A falling edge with enable_i=0 is ignored.
- START: at the k=0 sample, rs=0 goes to DATA with bit index 0. rs=1 is a glitch: return to IDLE with no flags and no output.
- DATA: at each sample, shift right with rs entering bit 7. After the 8th sample, go to STOP. The result is LSB-first: the first data bit ends in data bit 0.
- STOP: at the k=9 sample:
  - rs=0: set frame_err_o, discard the byte, go to WAIT_IDLE.
  - rs=1 and the output register is free: load data_o and set valid_o in the next cycle. The register is free when valid_o=0, or when valid_o=1 and ready_i=1 in the same cycle.
  - rs=1 and the output register is full: set overrun_o, drop the new byte, keep the old data_o and valid_o.
  - In both rs=1 cases, go to IDLE the next cycle. A start edge arriving a half bit later must be caught.
- WAIT_IDLE: stay until rs=1, then go to IDLE. A break condition therefore never produces repeated frames.
- Handshake: a transfer occurs when valid_o & ready_i. valid_o then deasserts the next cycle unless a load occurs in the same cycle; a load wins and valid_o stays 1 with the new data. ready_i is ignored while valid_o=0.
- Error flags: set has priority over clr_err_i in the same cycle. Flags never affect the reception of later frames.
- busy_o = (state != IDLE), registered with the state.
- enable_i falling mid-frame: the frame finishes and is delivered normally.
- Bit counter: counts down, reloads DIV-1 at each sample point, never wraps out of range.

Test Plan:
- DIV=8, send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1), ready_i=1 -> data_o=0xA5 and valid_o=1 for exactly one cycle, starting 1 cycle after the stop sample; no flags set.
- DIV=8, rx_i low for 2 cycles then high -> busy_o pulses; START rejects; valid_o stays 0; no flags set.
- DIV=8, send 0x3C with stop bit 0, hold line low for 30 cycles, then high, then send 0x81 -> frame_err_o=1 and no valid for 0x3C; 0x81 is delivered; frame_err_o stays 1 until clr_err_i pulses.
- DIV=8, ready_i=0, send 0x11 then 0x22 back-to-back -> data_o=0x11 with valid_o held and overrun_o=1. Then ready_i=1 for one cycle -> valid_o=0.
- DIV=8, ready_i=1, two frames with a minimum stop bit and no gap (0x55, 0xAA) -> both delivered in order; the second start edge is detected.
- Cases for enable_i and reset:
  - enable_i=0 at a start edge -> no frame starts.
  - enable_i dropped during DATA -> the frame still completes.
  - rst_i pulsed low mid-DATA -> all outputs 0 and FSM=IDLE; the next full frame (0x7E) is received correctly.
